// File: rtl/sdft_bin_scanner.sv
// rtl/sdft_bin_scanner.sv - walks every sliding-DFT bin, stores approximate magnitudes in a local buffer.
// Peak-bin tracking is built only when SDFT_SCAN_PEAK_EN is defined.
module sdft_bin_scanner #(
  parameter int freq_bins = 16,
  parameter int freq_w = 20,
  localparam int bin_addr_w = $clog2(freq_bins)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         scan_start,
  input  logic                         sdft_ready,
  input  logic signed [freq_w-1:0]     sdft_real,
  input  logic signed [freq_w-1:0]     sdft_imag,
  output logic                         sdft_read,
  output logic [bin_addr_w-1:0]        sdft_addr,
  output logic                         scan_busy,
  output logic                         scan_done,
  input  logic [bin_addr_w-1:0]        mag_addr,
  output logic [freq_w-1:0]            mag_out,
  output logic [bin_addr_w-1:0]        peak_bin,
  output logic [freq_w-1:0]            peak_mag
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_WAIT_LO = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_CALC    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [bin_addr_w-1:0] c_last_bin = bin_addr_w'(freq_bins - 1);
  localparam logic [freq_w-1:0]     c_one      = freq_w'(1);

  logic [2:0]                r_state;
  logic [bin_addr_w-1:0]     r_bin;
  logic                      r_read;
  logic                      r_busy;
  logic                      r_done;
  logic signed [freq_w-1:0]  r_re;
  logic signed [freq_w-1:0]  r_im;
  logic [freq_w-1:0]         r_mag_out;
  logic [freq_w-1:0]         r_mem [freq_bins];

  logic [freq_w-1:0]         w_re_u;
  logic [freq_w-1:0]         w_im_u;
  logic [freq_w-1:0]         w_abs_re;
  logic [freq_w-1:0]         w_abs_im;
  logic [freq_w-1:0]         w_max;
  logic [freq_w-1:0]         w_min;
  logic [freq_w-1:0]         w_mag;
  logic                      w_wr;
  logic                      w_start;

  // Two's-complement negate in freq_w bits: the most negative input maps to 2^(freq_w-1) exactly.
  assign w_re_u   = r_re;
  assign w_im_u   = r_im;
  assign w_abs_re = r_re[freq_w-1] ? (~w_re_u + c_one) : w_re_u;
  assign w_abs_im = r_im[freq_w-1] ? (~w_im_u + c_one) : w_im_u;
  assign w_max    = (w_abs_re >= w_abs_im) ? w_abs_re : w_abs_im;
  assign w_min    = (w_abs_re >= w_abs_im) ? w_abs_im : w_abs_re;
  assign w_mag    = w_max + (w_min >> 2);

  assign w_wr     = (r_state == S_CALC);
  assign w_start  = (r_state == S_IDLE) && scan_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_read  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_re    <= '0;
      r_im    <= '0;
    end else begin
      r_read <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (scan_start) begin
            r_bin   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (sdft_ready) begin
            r_read  <= 1'b1;
            r_state <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          // Ready falling is the core's acknowledgement of our read.
          if (!sdft_ready) r_state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (sdft_ready) begin
            r_re    <= sdft_real;
            r_im    <= sdft_imag;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_bin == c_last_bin) begin
            r_state <= S_DONE;
          end else begin
            r_bin   <= r_bin + 1'b1;
            r_state <= S_REQ;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Buffer contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_bin] <= w_mag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_mag_out <= '0;
    else       r_mag_out <= r_mem[mag_addr];
  end

`ifdef SDFT_SCAN_PEAK_EN
  logic [bin_addr_w-1:0] r_run_bin;
  logic [freq_w-1:0]     r_run_mag;
  logic [bin_addr_w-1:0] r_peak_bin;
  logic [freq_w-1:0]     r_peak_mag;

  // Strict compare keeps the lowest bin on ties; outputs move only when a scan completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run_bin  <= '0;
      r_run_mag  <= '0;
      r_peak_bin <= '0;
      r_peak_mag <= '0;
    end else begin
      if (w_start) begin
        r_run_bin <= '0;
        r_run_mag <= '0;
      end else if (w_wr && (w_mag > r_run_mag)) begin
        r_run_bin <= r_bin;
        r_run_mag <= w_mag;
      end
      if (r_state == S_DONE) begin
        r_peak_bin <= r_run_bin;
        r_peak_mag <= r_run_mag;
      end
    end
  end

  assign peak_bin = r_peak_bin;
  assign peak_mag = r_peak_mag;
`else
  assign peak_bin = '0;
  assign peak_mag = '0;
`endif

  assign sdft_read = r_read;
  assign sdft_addr = r_bin;
  assign scan_busy = r_busy;
  assign scan_done = r_done;
  assign mag_out   = r_mag_out;

endmodule

// File: tb/tb_sdft_bin_scanner.sv
// tb/tb_sdft_bin_scanner.sv - scoreboard bench for sdft_bin_scanner with a behavioural core model.
module tb_sdft_bin_scanner;
  localparam int NB = 16;
  localparam int FW = 20;
  localparam int AW = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 scan_start;
  logic                 sdft_ready;
  logic signed [FW-1:0] sdft_real;
  logic signed [FW-1:0] sdft_imag;
  logic                 sdft_read;
  logic [AW-1:0]        sdft_addr;
  logic                 scan_busy;
  logic                 scan_done;
  logic [AW-1:0]        mag_addr;
  logic [FW-1:0]        mag_out;
  logic [AW-1:0]        peak_bin;
  logic [FW-1:0]        peak_mag;

  sdft_bin_scanner #(.freq_bins(NB), .freq_w(FW)) dut (
    .clk(clk), .reset(reset), .scan_start(scan_start),
    .sdft_ready(sdft_ready), .sdft_real(sdft_real), .sdft_imag(sdft_imag),
    .sdft_read(sdft_read), .sdft_addr(sdft_addr),
    .scan_busy(scan_busy), .scan_done(scan_done),
    .mag_addr(mag_addr), .mag_out(mag_out),
    .peak_bin(peak_bin), .peak_mag(peak_mag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int tbl_re [NB];
  int tbl_im [NB];
  int model_lat;
  int exp_q [$];
  int mag_q [$];

  // Written only by the core model / monitor process below.
  int cnt = 0;
  int cur = 0;
  int read_cnt = 0;
  int done_cnt = 0;
  int width_err = 0;
  int obs_addr [256];
  bit prev_read = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_mag(input int re, input int im);
    int a, b;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    if (a >= b) return a + b / 4;
    return b + a / 4;
  endfunction

  // Core model: ready drops after a read, stays low model_lat extra cycles, then returns with data.
  always @(negedge clk) begin
    if (reset) begin
      sdft_ready = 1'b1;
      cnt = 0;
    end else begin
      if (sdft_read) begin
        obs_addr[read_cnt % 256] = int'(sdft_addr);
        read_cnt++;
        if (prev_read) width_err++;
        sdft_ready = 1'b0;
        cnt = model_lat;
        cur = int'(sdft_addr);
      end else if (!sdft_ready) begin
        if (cnt == 0) begin
          sdft_ready = 1'b1;
          sdft_real = FW'(tbl_re[cur]);
          sdft_imag = FW'(tbl_im[cur]);
        end else begin
          cnt--;
        end
      end
      if (scan_done) done_cnt++;
    end
    prev_read = sdft_read;
  end

  task automatic load_table(input int which);
    for (int b = 0; b < NB; b++) begin
      if (which == 1) begin
        tbl_re[b] = b * 100;
        tbl_im[b] = 0;
      end else begin
        tbl_re[b] = b * 40 - 300;
        tbl_im[b] = -(b * 13);
      end
    end
    if (which == 1) begin
      tbl_re[3] = -400;    tbl_im[3] = 300;
      tbl_re[7] = -524288; tbl_im[7] = -524288;
    end else begin
      tbl_re[4] = 900;     tbl_im[4] = 0;
      tbl_re[11] = -800;   tbl_im[11] = 400;
    end
  endtask

  task automatic run_scan(input int lat, input int restart_at, input int reset_at, input int exp_cyc);
    int base_r, base_d, base_w, cyc, nexp;
    bit busy_ok, peak_held, restarted, aborted;
    logic [AW-1:0] pb0;
    logic [FW-1:0] pm0;
    model_lat = lat;
    base_r = read_cnt;
    base_d = done_cnt;
    base_w = width_err;
    nexp = (reset_at >= 0) ? reset_at + 1 : NB;
    for (int i = 0; i < nexp; i++) exp_q.push_back(i);
    pb0 = peak_bin;
    pm0 = peak_mag;
    busy_ok = 1'b1;
    peak_held = 1'b1;
    restarted = 1'b0;
    aborted = 1'b0;
    scan_start = 1'b1;
    @(negedge clk); #1;
    cyc = 1;
    while (done_cnt == base_d && cyc < 5000 && !aborted) begin
      scan_start = 1'b0;
      if (!scan_busy) busy_ok = 1'b0;
      if (peak_bin !== pb0 || peak_mag !== pm0) peak_held = 1'b0;
      if (restart_at >= 0 && !restarted && (read_cnt - base_r) == restart_at + 1) begin
        scan_start = 1'b1;
        restarted = 1'b1;
      end
      if (reset_at >= 0 && (read_cnt - base_r) == reset_at + 1) begin
        reset = 1'b1;
        #1;
        check("rst_read", sdft_read, 0);
        check("rst_addr", sdft_addr, 0);
        check("rst_busy", scan_busy, 0);
        check("rst_done", scan_done, 0);
        check("rst_mag_out", mag_out, 0);
        check("rst_peak_bin", peak_bin, 0);
        check("rst_peak_mag", peak_mag, 0);
        aborted = 1'b1;
      end else begin
        @(negedge clk); #1;
        cyc++;
      end
    end
    scan_start = 1'b0;
    for (int i = 0; i < nexp; i++) check("read_addr", obs_addr[(base_r + i) % 256], exp_q.pop_front());
    check("read_width", width_err - base_w, 0);
    check("busy_held", busy_ok, 1);
    if (aborted) begin
      check("abort_reads", read_cnt - base_r, nexp);
      repeat (2) begin @(negedge clk); #1; end
      check("abort_no_done", done_cnt - base_d, 0);
      reset = 1'b0;
    end else begin
      check("peak_held", peak_held, 1);
      check("done_seen", done_cnt - base_d, 1);
      check("read_count", read_cnt - base_r, NB);
      check("busy_after", scan_busy, 0);
      if (exp_cyc >= 0) check("scan_cycles", cyc, exp_cyc);
      @(negedge clk); #1;
      check("done_pulse", done_cnt - base_d, 1);
      check("read_count_after", read_cnt - base_r, NB);
    end
  endtask

  task automatic check_mags();
    for (int b = 0; b < NB; b++) begin
      mag_addr = AW'(b);
      mag_q.push_back(exp_mag(tbl_re[b], tbl_im[b]));
      @(negedge clk); #1;
      check($sformatf("mag[%0d]", b), mag_out, mag_q.pop_front());
    end
  endtask

  task automatic check_peak(input int b, input int m);
`ifdef SDFT_SCAN_PEAK_EN
    check("peak_bin", peak_bin, b);
    check("peak_mag", peak_mag, m);
`else
    check("peak_bin", peak_bin, 0);
    check("peak_mag", peak_mag, 0);
`endif
  endtask

  initial begin
    reset = 1'b1;
    scan_start = 1'b0;
    mag_addr = '0;
    model_lat = 1;
    load_table(1);
    repeat (3) @(negedge clk);
    #1;
    check("reset_read", sdft_read, 0);
    check("reset_addr", sdft_addr, 0);
    check("reset_busy", scan_busy, 0);
    check("reset_done", scan_done, 0);
    check("reset_mag_out", mag_out, 0);
    check("reset_peak_bin", peak_bin, 0);
    check("reset_peak_mag", peak_mag, 0);
    reset = 1'b0;
    @(negedge clk); #1;

    run_scan(1, -1, -1, 82);
    check_mags();
    check_peak(7, 655360);

    load_table(2);
    run_scan(10, -1, -1, -1);
    check_mags();
    check_peak(4, 900);

    load_table(1);
    run_scan(1, 6, -1, -1);
    check_mags();
    check_peak(7, 655360);

    run_scan(1, -1, 9, -1);
    check_peak(0, 0);

    load_table(2);
    run_scan(1, -1, -1, 82);
    check_mags();
    check_peak(4, 900);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
